dm_access_ctrl: RTL



---
 rtl/dm_access_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/dm_access_ctrl.sv
// MEM-stage data-memory access controller: req/gnt/rvalid handshake, store lane alignment, load capture.
// Optional watchdog enabled by defining DM_TIMEOUT_EN (limit TIMEOUT_CYCLES).
module dm_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_load,
  input  logic        ex_store,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  output logic        lsu_stall,
  output logic        lsu_done,
  output logic        misalign_exc,
  output logic        bus_err,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_web,
  input  logic        dm_gnt,
  input  logic        dm_rvalid,
  input  logic [31:0] dm_rdata,
  output logic [31:0] ld_rdata,
  output logic [2:0]  ld_funct3,
  output logic [1:0]  ld_addr_lo,
  output logic [1:0]  dbg_state
);

  // Handshake: dm_req is held with stable addr/data/strobes until the cycle dm_gnt=1
  // (transfer happens that cycle); a load then waits for dm_rvalid=1, which is
  // accepted only while in WAIT. gnt outside REQ and rvalid outside WAIT are ignored.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;
  logic        store_q, mis_q, err_q;
  logic [31:0] ld_rdata_q;
  logic [2:0]  ld_funct3_q;
  logic [1:0]  ld_addr_lo_q;

  logic        new_op, mis_new, capture, rd_fire, abort, timeout;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_web;

  assign new_op = ex_valid & (ex_load | ex_store);

  // funct3[1]=1 covers LW/SW and the word-sized encodings 011/110/111
  always_comb begin
    mis_new = 1'b0;
    if (ex_funct3[1])      mis_new = (ex_addr[1:0] != 2'b00);
    else if (ex_funct3[0]) mis_new = ex_addr[0];
  end

`ifdef DM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt;

  // Abort on the last of TIMEOUT_CYCLES cycles spent waiting without the awaited event.
  assign timeout = ((state == S_REQ) || (state == S_WAIT)) &&
                   (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst)                                 tmo_cnt <= '0;
    else if (capture || (state == S_REQ && dm_gnt)) tmo_cnt <= '0;
    else if (state == S_REQ || state == S_WAIT)     tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign timeout        = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    rd_fire   = 1'b0;
    abort     = 1'b0;
    case (state)
      S_IDLE: begin
        if (new_op) begin
          capture   = 1'b1;
          state_nxt = mis_new ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (dm_gnt) begin
          state_nxt = store_q ? S_DONE : S_WAIT;
        end else if (timeout) begin
          abort     = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_WAIT: begin
        if (dm_rvalid) begin
          rd_fire   = 1'b1;
          state_nxt = S_DONE;
        end else if (timeout) begin
          abort     = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      size_q       <= '0;
      store_q      <= 1'b0;
      mis_q        <= 1'b0;
      err_q        <= 1'b0;
      ld_rdata_q   <= '0;
      ld_funct3_q  <= '0;
      ld_addr_lo_q <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        addr_q  <= ex_addr;
        wdata_q <= ex_wdata;
        size_q  <= ex_funct3[1:0];
        store_q <= ex_store;
        mis_q   <= mis_new;
        err_q   <= 1'b0;
        // the formatter context belongs to the last load; stores leave it alone
        if (ex_load) begin
          ld_funct3_q  <= ex_funct3;
          ld_addr_lo_q <= ex_addr[1:0];
        end
      end
      if (abort)   err_q      <= 1'b1;
      if (rd_fire) ld_rdata_q <= dm_rdata;
    end
  end

  always_comb begin
    lane_wdata = wdata_q;
    lane_web   = 4'b1111;
    if (!size_q[1]) begin
      if (size_q[0]) begin
        lane_wdata = {2{wdata_q[15:0]}};
        lane_web   = addr_q[1] ? 4'b1100 : 4'b0011;
      end else begin
        lane_wdata = {4{wdata_q[7:0]}};
        lane_web   = 4'b0001 << addr_q[1:0];
      end
    end
  end

  assign lsu_stall    = ((state == S_IDLE) && new_op) || (state == S_REQ) || (state == S_WAIT);
  assign lsu_done     = (state == S_DONE);
  assign misalign_exc = (state == S_DONE) && mis_q;
  assign bus_err      = (state == S_DONE) && err_q;
  assign dm_req       = (state == S_REQ);
  assign dm_we        = (state == S_REQ) && store_q;
  assign dm_addr      = {addr_q[31:2], 2'b00};
  assign dm_wdata     = lane_wdata;
  assign dm_web       = store_q ? lane_web : 4'b0000;
  assign ld_rdata     = ld_rdata_q;
  assign ld_funct3    = ld_funct3_q;
  assign ld_addr_lo   = ld_addr_lo_q;
  assign dbg_state    = state;

endmodule
